// File: rtl/spi_flash_cmd_ctrl.sv
// Serial-flash command sequencer: decodes opcode/address/data bytes from the SPI slave,
// drives the next transmit byte and issues byte-wide array reads and writes.
module spi_flash_cmd_ctrl #(
   parameter int          ADDR_WIDTH = 16,
   parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_busy,
   input  logic                  spi_rx_valid,
   input  logic [7:0]            spi_rx_data,
   output logic [7:0]            spi_tx_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   input  logic [7:0]            mem_rdata,
   output logic                  mem_we,
   output logic [7:0]            mem_wdata,
   output logic                  wel
);

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STATUS, S_ID, S_IGNORE
   } state_t;

   state_t                state_q, state_d;
   logic                  busy_q;
   logic                  wel_q, wel_d;
   logic                  is_pp_q, is_pp_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [15:0]           addr_q, addr_d;
   logic [7:0]            rd_byte_q, rd_byte_d;
   logic                  rd_wait_q, rd_wait_d;
   logic                  prog_inc_q, prog_inc_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_re_q, mem_re_d;
   logic                  mem_we_q, mem_we_d;
   logic [7:0]            mem_wdata_q, mem_wdata_d;

   logic                  busy_rise;
   logic                  busy_fall;
   logic [23:0]           addr_full;

   assign busy_rise = spi_busy & ~busy_q;
   assign busy_fall = busy_q & ~spi_busy;
   assign addr_full = {addr_q, spi_rx_data};

   // Address bits above the array width are accepted on the wire and discarded.
   generate
      if (ADDR_WIDTH < 24) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^addr_full[23:ADDR_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         wel_q       <= 1'b0;
         is_pp_q     <= 1'b0;
         cnt_q       <= 2'd0;
         addr_q      <= 16'h0000;
         rd_byte_q   <= 8'h00;
         rd_wait_q   <= 1'b0;
         prog_inc_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         busy_q      <= spi_busy;
         wel_q       <= wel_d;
         is_pp_q     <= is_pp_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rd_byte_q   <= rd_byte_d;
         rd_wait_q   <= rd_wait_d;
         prog_inc_q  <= prog_inc_d;
         mem_addr_q  <= mem_addr_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wel_d       = wel_q;
      is_pp_d     = is_pp_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rd_byte_d   = rd_byte_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      rd_wait_d   = mem_re_q;
      prog_inc_d  = 1'b0;

      // Read data lands one cycle after the strobe; then step to the next byte.
      if (rd_wait_q) begin
         rd_byte_d  = mem_rdata;
         mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
      end
      // Page program only advances the low byte so writes stay inside the page.
      if (prog_inc_q) begin
         mem_addr_d[7:0] = mem_addr_q[7:0] + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (busy_rise) begin
               state_d   = S_CMD;
               is_pp_d   = 1'b0;
               cnt_d     = 2'd0;
               rd_byte_d = 8'h00;
            end
         end
         S_CMD: begin
            if (spi_rx_valid) begin
               cnt_d = 2'd0;
               case (spi_rx_data)
                  OP_WREN: begin wel_d = 1'b1; state_d = S_IGNORE; end
                  OP_WRDI: begin wel_d = 1'b0; state_d = S_IGNORE; end
                  OP_RDSR: state_d = S_STATUS;
                  OP_RDID: state_d = S_ID;
                  OP_READ: begin is_pp_d = 1'b0; state_d = S_ADDR; end
                  OP_PP:   begin is_pp_d = 1'b1; state_d = S_ADDR; end
                  default: state_d = S_IGNORE;
               endcase
            end
         end
         S_ADDR: begin
            if (spi_rx_valid) begin
               addr_d = addr_full[15:0];
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd2) begin
                  mem_addr_d = addr_full[ADDR_WIDTH-1:0];
                  if (is_pp_q) begin
                     state_d = S_PROG;
                  end else begin
                     state_d  = S_READ;
                     mem_re_d = 1'b1;
                  end
               end
            end
         end
         S_READ: begin
            if (spi_rx_valid) mem_re_d = 1'b1;
         end
         S_PROG: begin
            if (spi_rx_valid) begin
               prog_inc_d = 1'b1;
               if (wel_q) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = spi_rx_data;
               end
            end
         end
         S_ID: begin
            if (spi_rx_valid && cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
         end
         default: ;
      endcase

      // End of transaction wins over the state change, after the byte is handled.
      if (state_q != S_IDLE && busy_fall) begin
         state_d = S_IDLE;
         if (is_pp_d) wel_d = 1'b0;
      end
   end

   always_comb begin
      spi_tx_data = 8'h00;
      case (state_q)
         S_READ:   spi_tx_data = rd_byte_q;
         S_STATUS: spi_tx_data = {6'b000000, wel_q, 1'b0};
         S_ID: begin
            case (cnt_q)
               2'd0:    spi_tx_data = JEDEC_ID[23:16];
               2'd1:    spi_tx_data = JEDEC_ID[15:8];
               2'd2:    spi_tx_data = JEDEC_ID[7:0];
               default: spi_tx_data = 8'h00;
            endcase
         end
         default: ;
      endcase
   end

   assign mem_addr  = mem_addr_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign wel       = wel_q;

endmodule

// File: tb/tb_spi_flash_cmd_ctrl.sv
// Bench for spi_flash_cmd_ctrl: directed vector table, hand-timed corner sequences and
// random transactions against a transaction-level flash model with its own memory image.
module tb_spi_flash_cmd_ctrl;

   localparam int AW  = 16;
   localparam int GAP = 6;

   logic          clk;
   logic          rst_n;
   logic          spi_busy;
   logic          spi_rx_valid;
   logic [7:0]    spi_rx_data;
   logic [7:0]    spi_tx_data;
   logic [AW-1:0] mem_addr;
   logic          mem_re;
   logic [7:0]    mem_rdata;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic          wel;

   spi_flash_cmd_ctrl #(.ADDR_WIDTH(AW), .JEDEC_ID(24'hEF4016)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_busy     (spi_busy),
      .spi_rx_valid (spi_rx_valid),
      .spi_rx_data  (spi_rx_data),
      .spi_tx_data  (spi_tx_data),
      .mem_addr     (mem_addr),
      .mem_re       (mem_re),
      .mem_rdata    (mem_rdata),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .wel          (wel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte array the DUT talks to (registered read).
   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   int          n_cmp = 0;
   int          n_fail = 0;
   int          txn_no = 0;
   logic [23:0] wr_log[$];
   logic [23:0] exp_wr[$];
   logic [7:0]  tb_bytes[16];
   logic [7:0]  tb_got[16];
   logic [7:0]  exp_tx[16];
   int          tb_n;
   logic        ref_wel;

   typedef struct {
      int          n;
      logic [63:0] b;
      logic [63:0] tx;
      logic        wel;
      int          nwr;
      logic [71:0] wr;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
      if (mem_re || mem_we) check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
   end

   function automatic logic [7:0] pat(input int i);
      logic [15:0] a;
      a = 16'(i);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      repeat (GAP) tick();
      spi_rx_data  = b;
      spi_rx_valid = 1'b1;
      tick();
      spi_rx_valid = 1'b0;
   endtask

   // Whole-transaction flash behaviour, computed from the command rules on the byte list.
   task automatic model_txn();
      logic [7:0]  op;
      logic [15:0] a;
      logic [15:0] wa;
      logic [23:0] jid;
      jid = 24'hEF4016;
      exp_wr.delete();
      for (int i = 0; i < 16; i++) exp_tx[i] = 8'h00;
      if (tb_n == 0) return;
      op = tb_bytes[0];
      a  = {tb_bytes[2], tb_bytes[3]};
      for (int i = 1; i < tb_n; i++) begin
         case (op)
            8'h05: exp_tx[i] = {6'b000000, ref_wel, 1'b0};
            8'h9F: if (i <= 3) exp_tx[i] = jid[23-8*(i-1) -: 8];
            8'h03: if (i >= 4) exp_tx[i] = ref_mem[a + 16'(i-4)];
            8'h02: if (i >= 4 && ref_wel) begin
               wa = {a[15:8], a[7:0] + 8'(i-4)};
               exp_wr.push_back({wa, tb_bytes[i]});
            end
            default: ;
         endcase
      end
      foreach (exp_wr[j]) ref_mem[exp_wr[j][23:8]] = exp_wr[j][7:0];
      if (op == 8'h06) ref_wel = 1'b1;
      if (op == 8'h04 || op == 8'h02) ref_wel = 1'b0;
   endtask

   task automatic run_txn();
      wr_log.delete();
      spi_busy = 1'b1;
      for (int i = 0; i < tb_n; i++) begin
         repeat (GAP) tick();
         tb_got[i]    = spi_tx_data;
         spi_rx_data  = tb_bytes[i];
         spi_rx_valid = 1'b1;
         tick();
         spi_rx_valid = 1'b0;
      end
      repeat (3) tick();
      spi_busy = 1'b0;
      repeat (3) tick();
      txn_no++;
      $display("txn %0d: op=%h bytes=%0d writes=%0d wel=%b", txn_no, tb_bytes[0], tb_n,
               wr_log.size(), wel);
   endtask

   task automatic check_txn(input string tag);
      for (int i = 0; i < tb_n; i++)
         check($sformatf("%s_tx%0d", tag, i), 32'(tb_got[i]), 32'(exp_tx[i]));
      check($sformatf("%s_nwr", tag), 32'(wr_log.size()), 32'(exp_wr.size()));
      for (int j = 0; j < exp_wr.size() && j < wr_log.size(); j++)
         check($sformatf("%s_wr%0d", tag, j), 32'(wr_log[j]), 32'(exp_wr[j]));
      check($sformatf("%s_wel", tag), 32'(wel), 32'(ref_wel));
   endtask

   task automatic one_byte_txn(input logic [7:0] op, input string tag);
      tb_n = 1;
      tb_bytes[0] = op;
      model_txn();
      run_txn();
      check_txn(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx"},    32'(spi_tx_data), 32'h00);
      check({tag, "_addr"},  32'(mem_addr),    32'h0000);
      check({tag, "_re"},    32'(mem_re),      32'd0);
      check({tag, "_we"},    32'(mem_we),      32'd0);
      check({tag, "_wdata"}, 32'(mem_wdata),   32'h00);
      check({tag, "_wel"},   32'(wel),         32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = pat(i);
         ref_mem[i] = pat(i);
      end
      ref_wel      = 1'b0;
      rst_n        = 1'b0;
      spi_busy     = 1'b0;
      spi_rx_valid = 1'b0;
      spi_rx_data  = 8'h00;

      vecs[0]  = '{2, 64'h05_00_00_00_00_00_00_00, 64'h0, 1'b0, 0, 72'h0};
      vecs[1]  = '{1, 64'h06_00_00_00_00_00_00_00, 64'h0, 1'b1, 0, 72'h0};
      vecs[2]  = '{3, 64'h05_00_00_00_00_00_00_00, 64'h00_02_02_00_00_00_00_00, 1'b1, 0, 72'h0};
      vecs[3]  = '{1, 64'h04_00_00_00_00_00_00_00, 64'h0, 1'b0, 0, 72'h0};
      vecs[4]  = '{2, 64'h05_00_00_00_00_00_00_00, 64'h0, 1'b0, 0, 72'h0};
      vecs[5]  = '{6, 64'h9F_00_00_00_00_00_00_00, 64'h00_EF_40_16_00_00_00_00, 1'b0, 0, 72'h0};
      vecs[6]  = '{1, 64'h06_00_00_00_00_00_00_00, 64'h0, 1'b1, 0, 72'h0};
      vecs[7]  = '{6, 64'h02_00_00_10_A5_5A_00_00, 64'h0, 1'b0, 2, 72'h0010A5_00115A_000000};
      vecs[8]  = '{2, 64'h05_00_00_00_00_00_00_00, 64'h0, 1'b0, 0, 72'h0};
      vecs[9]  = '{6, 64'h02_00_00_10_11_22_00_00, 64'h0, 1'b0, 0, 72'h0};
      vecs[10] = '{6, 64'h03_00_00_10_00_00_00_00, 64'h00_00_00_00_A5_5A_00_00, 1'b0, 0, 72'h0};
      vecs[11] = '{1, 64'h06_00_00_00_00_00_00_00, 64'h0, 1'b1, 0, 72'h0};
      vecs[12] = '{7, 64'h02_00_00_FF_11_22_33_00, 64'h0, 1'b0, 3, 72'h00FF11_000022_000133};
      vecs[13] = '{6, 64'h03_12_FF_FF_00_00_00_00, 64'h00_00_00_00_3C_22_00_00, 1'b0, 0, 72'h0};
      vecs[14] = '{3, 64'hAB_55_66_00_00_00_00_00, 64'h0, 1'b0, 0, 72'h0};

      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (3) tick();

      // Directed vector table.
      for (int k = 0; k < 15; k++) begin
         tb_n = vecs[k].n;
         for (int i = 0; i < 16; i++) tb_bytes[i] = 8'h00;
         for (int i = 0; i < 8; i++) tb_bytes[i] = vecs[k].b[63-8*i -: 8];
         model_txn();
         run_txn();
         for (int i = 0; i < tb_n; i++)
            check($sformatf("vec%0d_tx%0d", k, i), 32'(tb_got[i]), 32'(vecs[k].tx[63-8*i -: 8]));
         check($sformatf("vec%0d_nwr", k), 32'(wr_log.size()), 32'(vecs[k].nwr));
         for (int j = 0; j < vecs[k].nwr && j < wr_log.size(); j++)
            check($sformatf("vec%0d_wr%0d", k, j), 32'(wr_log[j]), 32'(vecs[k].wr[71-24*j -: 24]));
         check($sformatf("vec%0d_wel", k), 32'(wel), 32'(vecs[k].wel));
      end

      // READ latency: strobe 1 cycle after the last address byte, data 3 cycles after.
      wr_log.delete();
      spi_busy = 1'b1;
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (GAP) tick();
      spi_rx_data  = 8'h10;
      spi_rx_valid = 1'b1;
      tick();
      spi_rx_valid = 1'b0;
      check("rd_lat_re",   32'(mem_re),   32'd1);
      check("rd_lat_addr", 32'(mem_addr), 32'h0010);
      tick();
      check("rd_lat_re_off", 32'(mem_re),      32'd0);
      check("rd_lat_tx_old", 32'(spi_tx_data), 32'h00);
      tick();
      check("rd_lat_tx", 32'(spi_tx_data), 32'(ref_mem[16'h0010]));
      repeat (3) tick();
      spi_busy = 1'b0;
      repeat (3) tick();
      txn_no++;
      $display("txn %0d: op=03 read latency sequence", txn_no);

      // Last PP byte arrives in the same cycle chip select drops.
      one_byte_txn(8'h06, "seqb_wren");
      wr_log.delete();
      spi_busy = 1'b1;
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'h00);
      repeat (GAP) tick();
      spi_rx_data  = 8'h77;
      spi_rx_valid = 1'b1;
      spi_busy     = 1'b0;
      tick();
      spi_rx_valid = 1'b0;
      check("fall_we",    32'(mem_we),    32'd1);
      check("fall_addr",  32'(mem_addr),  32'h2000);
      check("fall_wdata", 32'(mem_wdata), 32'h77);
      tick();
      check("fall_we_off", 32'(mem_we), 32'd0);
      repeat (3) tick();
      check("fall_nwr", 32'(wr_log.size()), 32'd1);
      check("fall_wel", 32'(wel), 32'd0);
      ref_mem[16'h2000] = 8'h77;
      ref_wel = 1'b0;
      txn_no++;
      $display("txn %0d: op=02 write with chip select dropping on last byte", txn_no);

      // Reset in the middle of a page program.
      one_byte_txn(8'h06, "seqr_wren");
      wr_log.delete();
      spi_busy = 1'b1;
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      rst_n = 1'b0;
      #2;
      check_reset_outputs("midrst");
      send_byte(8'h22);
      send_byte(8'h99);
      spi_busy = 1'b0;
      repeat (2) tick();
      check("midrst_nwr", 32'(wr_log.size()), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      ref_wel = 1'b0;
      txn_no++;
      $display("txn %0d: op=02 aborted by reset", txn_no);
      tb_n = 2;
      tb_bytes[0] = 8'h05;
      tb_bytes[1] = 8'h00;
      model_txn();
      run_txn();
      check_txn("post_rst_rdsr");

      // Random transactions against the model.
      for (int t = 0; t < 40; t++) begin
         int          r;
         int          sel;
         logic [7:0]  op;
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    op = 8'h06;
            2:       op = 8'h04;
            3:       op = 8'h05;
            4:       op = 8'h9F;
            5:       op = 8'h03;
            6, 7:    op = 8'h02;
            default: begin
               op = 8'($urandom_range(0, 255));
               if (op == 8'h06 || op == 8'h04 || op == 8'h05 || op == 8'h9F ||
                   op == 8'h03 || op == 8'h02) op = 8'hC7;
            end
         endcase
         tb_n = (op == 8'h06 || op == 8'h04) ? 1 : 2 + $urandom_range(0, 6);
         for (int i = 0; i < 16; i++) tb_bytes[i] = 8'($urandom_range(0, 255));
         tb_bytes[0] = op;
         sel = $urandom_range(0, 3);
         case (sel)
            1:       tb_bytes[3] = 8'hFC + 8'($urandom_range(0, 3));
            2:       begin tb_bytes[2] = 8'hFF; tb_bytes[3] = 8'hFE + 8'($urandom_range(0, 1)); end
            3:       tb_bytes[2] = 8'h00;
            default: ;
         endcase
         model_txn();
         run_txn();
         check_txn($sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
